// File: rtl/hamming74_uart_tx_if.sv
// Request-side handshake bundle for the Hamming(7,4) UART transmitter.
// The master drives the nibble, the error-injection position and valid.
// The slave (the transmitter) returns ready.
interface hamming74_uart_tx_if;
  logic [3:0] in_data;
  logic [2:0] in_err_pos;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_err_pos,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_err_pos,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/hamming74_uart_tx.sv
// Hamming(7,4) UART transmitter.
// - Encodes a nibble into a 7-bit codeword, with optional single-bit error injection.
// - Sends one UART frame: start bit, 7 code bits LSB first, optional even parity, stop bit.
// Optional feature macro: PARITY_BIT_EN adds an even-parity bit after the code bits,
// giving a 10-bit frame instead of a 9-bit frame.
module hamming74_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  hamming74_uart_tx_if.slave       s_if,
  output logic                     tx,
  output logic                     busy,
  output logic                     tx_done,
  output logic [6:0]               code_out,
  output logic [2:0]               state_out
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    idx_reg, idx_next;
  logic [6:0]    code_reg, code_next;
  logic          tx_reg, tx_next;

  logic [6:0]    code_clean;
  logic [6:0]    err_mask;
  logic          accept;
  logic          cnt_last;

  // Codeword bit i corresponds to Hamming position i+1: {d3,d2,d1,p3,d0,p2,p1}.
  assign code_clean = {s_if.in_data[3],
                       s_if.in_data[2],
                       s_if.in_data[1],
                       s_if.in_data[1] ^ s_if.in_data[2] ^ s_if.in_data[3],
                       s_if.in_data[0],
                       s_if.in_data[0] ^ s_if.in_data[2] ^ s_if.in_data[3],
                       s_if.in_data[0] ^ s_if.in_data[1] ^ s_if.in_data[3]};

  // One-hot error mask: position p (1..7) flips codeword bit p-1; 0 flips nothing.
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_err_mask
      assign err_mask[gi] = (s_if.in_err_pos == 3'(gi + 1));
    end
  endgenerate

  assign s_if.in_ready = (state_reg == IDLE) && !rst;
  assign accept        = s_if.in_valid && s_if.in_ready && ena;
  assign cnt_last      = (cnt_reg == CW'(CLKS_PER_BIT - 1));

  // Next-state logic: bit timing, bit index and codeword latch; holds everything while ena is low.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    code_next  = code_reg;
    if (ena) begin
      if (state_reg == IDLE) begin
        if (accept) begin
          state_next = START;
          cnt_next   = '0;
          code_next  = code_clean ^ err_mask;
        end
      end else if (cnt_last) begin
        cnt_next = '0;
        case (state_reg)
          START: begin
            state_next = DATA;
            idx_next   = 3'd0;
          end
          DATA: begin
            if (idx_reg == 3'd6) begin
`ifdef PARITY_BIT_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              idx_next = idx_reg + 3'd1;
            end
          end
          PARITY:  state_next = STOP;
          default: state_next = IDLE;
        endcase
      end else begin
        cnt_next = cnt_reg + CW'(1);
      end
    end
  end

  // Line level for the upcoming cycle, derived from the next state so tx is a clean register.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = code_next[idx_next];
      PARITY:  tx_next = ^code_next;
      default: tx_next = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame in progress and returns the line to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= 3'd0;
      code_reg  <= 7'd0;
      tx_reg    <= 1'b1;
    end else if (ena) begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      code_reg  <= code_next;
      tx_reg    <= tx_next;
    end
  end

  assign tx        = tx_reg;
  assign busy      = (state_reg != IDLE);
  assign tx_done   = (state_reg == STOP) && cnt_last;
  assign code_out  = code_reg;
  assign state_out = state_reg;

endmodule
